// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, SPI phase constants and width helper for the SPI master
package spi_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] TRAIL = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam bit CPHA_LEAD_SAMPLE = 1'b0;
  localparam bit CPHA_LEAD_SHIFT  = 1'b1;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/zrb_spi_tick_gen.sv
// zrb_spi_tick_gen: CLK_DIV down-counter with synchronous clear emitting a one-cycle tick
module zrb_spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = clogb2(CLK_DIV);
  localparam logic [W-1:0] LOAD = W'(CLK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = !clear && cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (clear || tick) cnt <= LOAD;
    else cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/zrb_spi_master.sv
// zrb_spi_master: SPI bus master generating SCK/CS, shifting a word out MSB-first and capturing the reply
module zrb_spi_master
  import spi_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] data_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] data_out,
  output logic                sck,
  output logic                cs,
  output logic                spi_out,
  input  logic                spi_in
);
  localparam int EW = clogb2(2 * NUM_BITS + 1);
  localparam logic [EW-1:0] EDGES = EW'(2 * NUM_BITS);
  logic [2:0] state;
  logic [EW-1:0] edges;
  logic [NUM_BITS-1:0] tx, rx;
  logic tick, last_edge, sample_edge, shift_edge;
  zrb_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );
  // sck still at idle level means this toggle is the leading edge
  assign sample_edge = (sck == CPOL) ^ (CPHA == CPHA_LEAD_SHIFT);
  assign last_edge = edges == EW'(1);
  assign shift_edge = !sample_edge && !last_edge;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      edges    <= '0;
      tx       <= '0;
      rx       <= '0;
      cs       <= 1'b1;
      sck      <= CPOL;
      spi_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state   <= LEAD;
          busy    <= 1'b1;
          cs      <= 1'b0;
          tx      <= (CPHA == CPHA_LEAD_SAMPLE) ? data_in << 1 : data_in;
          spi_out <= (CPHA == CPHA_LEAD_SAMPLE) ? data_in[NUM_BITS-1] : 1'b0;
        end
      end else if (tick) begin
        case (state)
          LEAD: begin
            state <= SHIFT;
            edges <= EDGES;
          end
          SHIFT: begin
            sck   <= ~sck;
            edges <= edges - 1'b1;
            if (sample_edge) rx <= {rx[NUM_BITS-2:0], spi_in};
            if (shift_edge) begin
              spi_out <= tx[NUM_BITS-1];
              tx      <= tx << 1;
            end
            if (last_edge) state <= TRAIL;
          end
          TRAIL: begin
            cs       <= 1'b1;
            spi_out  <= 1'b0;
            done     <= 1'b1;
            data_out <= rx;
            state    <= GAP;
          end
          GAP: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_zrb_spi_master.sv
// tb_zrb_spi_master: three master configurations against a bus-level SPI slave model with random words
module tb_zrb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int N = (g == 2) ? 16 : 8;
    localparam int CD = (g == 2) ? 5 : 4;
    localparam bit POL = (g == 1);
    localparam bit PHA = (g == 1);
    localparam int LAT = 1 + CD * (2 * N + 2);
    localparam int P = 1 + CD * (2 * N + 3);
    localparam logic [N-1:0] V_TX = (g == 1) ? N'('h3C) : (g == 2) ? N'('h8001) : N'('hA5);
    localparam logic [N-1:0] V_RX = (g == 1) ? N'('hC3) : V_TX;
    logic reset = 1'b1, start = 1'b0, spi_in = 1'b0, fin = 1'b0;
    logic busy, done, sck, cs, spi_out;
    logic [N-1:0] data_in = '0, data_out;
    zrb_spi_master #(.NUM_BITS(N), .CPOL(POL), .CPHA(PHA), .CLK_DIV(CD)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .busy(busy), .done(done),
      .data_out(data_out), .sck(sck), .cs(cs), .spi_out(spi_out), .spi_in(spi_in)
    );
    // slave: samples MOSI on its sampling edge, drives MISO on the other edge
    logic [N-1:0] preload = '0, s_tx, s_rx, s_word;
    logic p_cs = 1'b1, p_sck = POL, p_mo = 1'b0;
    int rises = 0, dones = 0, bad_mo = 0;
    always @(negedge clk) begin
      if (p_cs && !cs) begin
        s_tx = preload;
        spi_in = PHA ? 1'b0 : s_tx[N-1];
        if (!PHA) s_tx = s_tx << 1;
      end else if (!cs && sck != p_sck) begin
        if ((sck != POL) ^ PHA) s_rx = {s_rx[N-2:0], spi_out};
        else begin
          spi_in = s_tx[N-1];
          s_tx = s_tx << 1;
        end
        if (sck && !p_sck) rises++;
      end
      if (!cs && !p_cs && spi_out != p_mo && !(sck != p_sck && !((sck != POL) ^ PHA))) bad_mo++;
      if (!p_cs && cs) s_word = s_rx;
      if (done) dones++;
      p_cs = cs;
      p_sck = sck;
      p_mo = spi_out;
    end
    task automatic frame(input logic [N-1:0] tx, input logic [N-1:0] pre);
      int n, dn, d0, r0, b0;
      preload = pre;
      data_in = tx;
      start = 1'b1;
      d0 = dones; r0 = rises; b0 = bad_mo;
      n = 0; dn = 0;
      while (n < 4000) begin
        @(negedge clk);
        n++;
        if (n == 1) check($sformatf("g%0d_cs_assert", g), cs, 0);
        start = ($urandom_range(0, 3) == 0);
        data_in = N'($urandom);
        if (done && dn == 0) dn = n;
        if (dn != 0 && !busy) break;
      end
      start = 1'b0;
      check($sformatf("g%0d_done_cycle", g), dn, LAT);
      check($sformatf("g%0d_busy_fall", g), n, dn + CD);
      check($sformatf("g%0d_data_out", g), data_out, pre);
      check($sformatf("g%0d_slave_rx", g), s_word, tx);
      check($sformatf("g%0d_sck_rises", g), rises - r0, N);
      check($sformatf("g%0d_done_pulses", g), dones - d0, 1);
      check($sformatf("g%0d_mosi_edges", g), bad_mo - b0, 0);
      check($sformatf("g%0d_idle_lines", g), {cs, sck, spi_out}, {1'b1, POL, 1'b0});
    endtask
    task automatic held(input logic [N-1:0] tx, input logic [N-1:0] pre);
      int n, d0, gap, low;
      preload = pre;
      data_in = tx;
      start = 1'b1;
      d0 = dones; gap = 0; low = 0; n = 0;
      while (n < 4 * P) begin
        @(negedge clk);
        n++;
        if (busy && cs) gap++;
        if (!busy && n <= 2 * P) low++;
        if (n == 2 * P + 1) start = 1'b0;
        if (n > 2 * P + 1 && !busy) break;
      end
      check($sformatf("g%0d_held_dones", g), dones - d0, 3);
      check($sformatf("g%0d_held_cs_gap", g), gap, 3 * CD);
      check($sformatf("g%0d_held_busy_low", g), low, 2);
      check($sformatf("g%0d_held_end", g), n, 3 * P);
      check($sformatf("g%0d_held_data", g), data_out, pre);
      check($sformatf("g%0d_held_slave", g), s_word, tx);
    endtask
    task automatic abort();
      int d0;
      preload = N'($urandom);
      data_in = N'($urandom);
      start = 1'b1;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      check($sformatf("g%0d_abort_lines", g), {cs, sck, spi_out, busy, done}, {1'b1, POL, 3'b000});
      check($sformatf("g%0d_abort_dout", g), data_out, 0);
      reset = 1'b0;
      d0 = dones;
      repeat (2 * CD * N) @(negedge clk);
      check($sformatf("g%0d_abort_no_done", g), dones - d0, 0);
      check($sformatf("g%0d_abort_idle", g), busy, 0);
      frame('1, N'($urandom));
    endtask
    initial begin
      repeat (3) @(negedge clk);
      check($sformatf("g%0d_rst_lines", g), {cs, sck, spi_out, busy, done}, {1'b1, POL, 3'b000});
      check($sformatf("g%0d_rst_dout", g), data_out, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      frame(V_TX, V_RX);
      frame(N'('h5A), N'('h96));
      frame('0, '1);
      frame('1, '0);
      for (int i = 0; i < 6; i++) frame(N'($urandom), N'($urandom));
      held(N'($urandom), N'($urandom));
      abort();
      fin = 1'b1;
    end
  end
  initial begin
    int t;
    t = 0;
    while (!(u[0].fin && u[1].fin && u[2].fin) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("all_finished", {u[0].fin, u[1].fin, u[2].fin}, 3'b111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
